// File: rtl/riscv_core_div_pkg.sv
// Shared definitions for the sequential RISC-V divider: FSM encoding,
// operation codes and small decode helpers.
package riscv_core_div_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t S_IDLE = 2'd0;
  localparam div_state_t S_CALC = 2'd1;
  localparam div_state_t S_FIX  = 2'd2;
  localparam div_state_t S_DONE = 2'd3;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_core_div_prep.sv
// Operand conditioning at request time: magnitudes, sign flags and the
// divide-by-zero / signed-overflow bypass detection at the active width.
module riscv_core_div_prep
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [1:0]      control,
  input  logic            isword,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] a_ext,
  output logic            a_neg,
  output logic            b_neg,
  output logic            div_zero,
  output logic            overflow
);

  localparam logic [XLEN-1:0] W_MASK = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W  = XLEN'(32'h8000_0000);

  logic            sgn;
  logic [XLEN-1:0] act_mask;
  logic [XLEN-1:0] a_w;
  logic [XLEN-1:0] b_w;

  always_comb begin
    sgn      = op_is_signed(control);
    act_mask = isword ? W_MASK : '1;
    a_w      = src_a & act_mask;
    b_w      = src_b & act_mask;
    a_neg    = sgn & (isword ? src_a[31] : src_a[XLEN-1]);
    b_neg    = sgn & (isword ? src_b[31] : src_b[XLEN-1]);
    // Negation is masked back to the active width so a W magnitude never
    // picks up ones above bit 31.
    a_mag    = a_neg ? (('0 - a_w) & act_mask) : a_w;
    b_mag    = b_neg ? (('0 - b_w) & act_mask) : b_w;
    div_zero = (b_w == '0);
    overflow = sgn & ~div_zero & (a_w == (isword ? MIN_W : MIN_X)) & (b_w == act_mask);
    if (isword)
      a_ext = src_a[31] ? (src_a | ~W_MASK) : (src_a & W_MASK);
    else
      a_ext = src_a;
  end

endmodule

// File: rtl/riscv_core_div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU and their W variants,
// retiring BITS_PER_CYCLE quotient bits per CALC cycle.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | shift-subtract iterations, down-counter to terminal count 0
// FIX   | sign correction and W sign-extension into the result register
// DONE  | result valid, held until the consumer accepts
module riscv_core_div_seq
  import riscv_core_div_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  input  logic            i_div_ready,
  output logic [XLEN-1:0] o_div_result,
  output logic            o_div_busy
);

  localparam int               CNT_W   = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_X   = CNT_W'(XLEN / BITS_PER_CYCLE - 1);
  localparam logic [CNT_W-1:0] CNT_W32 = CNT_W'(32 / BITS_PER_CYCLE - 1);
  localparam logic [XLEN-1:0]  W_MASK  = XLEN'(32'hFFFF_FFFF);

  div_state_t       state;
  logic [1:0]       op_q;
  logic             isword_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic             isword_eff;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic [XLEN-1:0]  a_ext;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             overflow;

  assign isword_eff  = (XLEN == 64) && i_div_isword;
  assign o_div_ready = (state == S_IDLE);
  assign o_div_busy  = (state != S_IDLE);
  assign o_div_valid = (state == S_DONE);

  riscv_core_div_prep #(.XLEN(XLEN)) u_prep (
    .src_a    (i_div_srcA),
    .src_b    (i_div_srcB),
    .control  (i_div_control),
    .isword   (isword_eff),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .a_ext    (a_ext),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  // The dividend is left-aligned in quo_q and shifted out MSB-first while
  // quotient bits shift in at the LSB.
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN:0]   part;

  always_comb begin
    quo_nx = quo_q;
    rem_nx = rem_q;
    part   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      part   = {rem_nx, quo_nx[XLEN-1]};
      quo_nx = {quo_nx[XLEN-2:0], 1'b0};
      if (part >= {1'b0, dvs_q}) begin
        part      = part - {1'b0, dvs_q};
        quo_nx[0] = 1'b1;
      end
      rem_nx = part[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] res_raw;
  logic [XLEN-1:0] res_fix;

  always_comb begin
    res_raw = op_is_rem(op_q) ? rem_q : quo_q;
    if (op_is_rem(op_q) ? neg_rem_q : neg_quo_q)
      res_raw = '0 - res_raw;
    if (isword_q)
      res_fix = res_raw[31] ? (res_raw | ~W_MASK) : (res_raw & W_MASK);
    else
      res_fix = res_raw;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      op_q         <= '0;
      isword_q     <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvs_q        <= '0;
      cnt_q        <= '0;
      o_div_result <= '0;
    end else if (i_div_flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_div_valid) begin
            op_q     <= i_div_control;
            isword_q <= isword_eff;
            if (div_zero || overflow) begin
              // Bypass results are loaded pre-signed; FIX only sign-extends.
              quo_q     <= div_zero ? '1 : a_ext;
              rem_q     <= div_zero ? a_ext : '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
              state     <= S_FIX;
            end else begin
              quo_q     <= isword_eff ? (a_mag << (XLEN - 32)) : a_mag;
              rem_q     <= '0;
              dvs_q     <= b_mag;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= isword_eff ? CNT_W32 : CNT_X;
              state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          if (cnt_q == '0)
            state <= S_FIX;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          o_div_result <= res_fix;
          state        <= S_DONE;
        end
        S_DONE: begin
          if (i_div_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_core_div_seq.md
RISCV_CORE_DIV_SEQ -- requirements
Module: riscv_core_div_seq

Interface
REQ-001 Parameter: XLEN, 64, datapath width; legal values are 32 and 64.
REQ-002 Parameter: BITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; legal values are 1, 2 and 4, and the value SHALL divide XLEN/2.
REQ-003 Port: i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port: i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: i_div_valid, input, 1, operation request.
REQ-006 Port: o_div_ready, output, 1, the unit accepts a request (high only in IDLE).
REQ-007 Port: i_div_srcA, input, XLEN, dividend source.
REQ-008 Port: i_div_srcB, input, XLEN, divisor source.
REQ-009 Port: i_div_control, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-010 Port: i_div_isword, input, 1, selects the W variant (operates on bits [31:0]; XLEN=64 only).
REQ-011 Port: i_div_flush, input, 1, abort the in-flight operation.
REQ-012 Port: o_div_valid, output, 1, result available.
REQ-013 Port: i_div_ready, input, 1, consumer accepts the result.
REQ-014 Port: o_div_result, output, XLEN, quotient or remainder.
REQ-015 Port: o_div_busy, output, 1, high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-017 IDLE->CALC SHALL occur on i_div_valid&&o_div_ready; the operands, control and isword are registered on that edge and the inputs are then don't-care.
REQ-018 Operand conditioning at capture: signed ops (DIV, REM) take the magnitude of each operand using the sign at bit XLEN-1, or bit 31 when isword; unsigned ops take the raw value, or the zero-extended [31:0] when isword.
REQ-019 Signed REM and REMW SHALL use the same sign bits as DIV and DIVW respectively.
REQ-020 CALC performs a restoring shift-subtract over N=XLEN bits (N=32 when isword), BITS_PER_CYCLE bits per cycle, using an iteration counter.
REQ-021 CALC SHALL last N/BITS_PER_CYCLE cycles, followed by one FIX cycle and then DONE.
REQ-022 FIX: quotient negated when the operand signs differ (signed ops only); remainder takes the dividend's sign.
REQ-023 Divide by zero SHALL bypass CALC (IDLE->FIX): quotient = all ones, remainder = dividend (original, unnegated).
REQ-024 Signed overflow (most negative value / -1 at the active width) SHALL bypass CALC: quotient = dividend, remainder = 0.
REQ-025 W results SHALL be the 32-bit result sign-extended from bit 31 to XLEN, including DIVUW and REMUW.
REQ-026 DONE holds o_div_valid=1 and o_div_result stable until i_div_ready; on the i_div_ready edge the FSM returns to IDLE.
REQ-027 Back-to-back operation: o_div_ready is low during the DONE-to-IDLE transfer cycle, and the next request is accepted the following cycle.
REQ-028 i_div_flush in any state SHALL force IDLE on the next edge with o_div_valid=0; flush has priority over i_div_valid and over i_div_ready.
REQ-029 Latency from accept to o_div_valid SHALL be N/BITS_PER_CYCLE+2 cycles normally and 2 cycles on a bypass.

Reset
REQ-030 On i_rst_n low, asynchronously: state=IDLE, o_div_valid=0, o_div_busy=0, o_div_result=0, counter=0, and all datapath registers=0.
REQ-031 o_div_ready SHALL be 1 from the first edge after reset deassertion; a reset asserted mid-CALC discards the operation with no output.

Structure
REQ-032 The state enum, the operation codes (DIV/DIVU/REM/REMU) and the shared package riscv_core_div_pkg SHALL be defined together in that package.
REQ-033 Operand conditioning SHALL be one combinational sub-module, riscv_core_div_prep, with XLEN as a parameter.

Verification
REQ-034 DIV, srcA=-20, srcB=3 -> result -6 after 66 cycles (XLEN=64, BITS_PER_CYCLE=1).
REQ-035 REM, srcA=-20, srcB=3 -> result -2; REMU, srcA=20, srcB=0 -> result 20, 2-cycle latency.
REQ-036 DIV, srcA=0x8000_0000_0000_0000, srcB=-1 -> result 0x8000_0000_0000_0000; REM on the same operands -> result 0.
REQ-037 DIVW, srcA=0xFFFF_FFFF_8000_0000, srcB=2 -> result 0xFFFF_FFFF_C000_0000 after 34 cycles; DIVUW with the same operands -> result 0x0000_0000_4000_0000.
REQ-038 i_div_ready held low for 5 cycles in DONE -> o_div_valid and o_div_result stable throughout; i_div_flush pulsed mid-CALC -> IDLE next cycle with no o_div_valid.
REQ-039 BITS_PER_CYCLE=4, DIVU, srcA=100, srcB=7 -> result 14 after 18 cycles.
